// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable down-counter with a start/done handshake. Counts
//                down from a programmed value, pulses done for one cycle at
//                terminal count, and can optionally reload and restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
   parameter int WIDTH       = 4,
   parameter int AUTO_RELOAD = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_value,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0] c_zero = '0;
   localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nx;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nx;
   logic [WIDTH-1:0] r_reload;
   logic [WIDTH-1:0] w_reload_nx;
   logic             r_busy;
   logic             r_done;

   // Decrement is a ripple add of all-ones: sum = a ^ 1 ^ c, carry = a | c.
   logic [WIDTH-1:0] w_dec;
   logic [WIDTH-1:0] w_carry;

   assign w_carry[0] = 1'b0;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_dec
         assign w_dec[i] = ~(r_count[i] ^ w_carry[i]);
         if (i < WIDTH-1) begin : g_carry
            assign w_carry[i+1] = r_count[i] | w_carry[i];
         end
      end
   endgenerate

   // Next-state, next-count and reload selection for the three-state control.
   always_comb begin
      w_state_nx  = r_state;
      w_count_nx  = r_count;
      w_reload_nx = r_reload;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_count_nx  = load_value;
               w_reload_nx = load_value;
               w_state_nx  = (load_value != c_zero) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (abort) begin
               w_state_nx = S_IDLE;
               w_count_nx = c_zero;
            end else if (!pause) begin
               w_count_nx = w_dec;
               if (r_count == c_one) begin
                  w_state_nx = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (abort) begin
               w_state_nx = S_IDLE;
               w_count_nx = c_zero;
            end else if (start) begin
               // Back-to-back start takes precedence over auto-reload.
               w_count_nx  = load_value;
               w_reload_nx = load_value;
               w_state_nx  = (load_value != c_zero) ? S_RUN : S_DONE;
            end else if ((AUTO_RELOAD != 0) && (r_reload != c_zero)) begin
               w_count_nx = r_reload;
               w_state_nx = S_RUN;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // State, count and reload registers; busy/done registered from next state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_count  <= c_zero;
         r_reload <= c_zero;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_count  <= w_count_nx;
         r_reload <= w_reload_nx;
         r_busy   <= (w_state_nx == S_RUN);
         r_done   <= (w_state_nx == S_DONE);
      end
   end

   assign count = r_count;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule
`default_nettype wire
